// File: rtl/sr_cmd_gen.sv
// Push-button front end for sr_ff: two-flop sync and debounce per button, then an
// arbitration FSM that emits single-period s/r strobes and locks out overlapping presses.

module sr_cmd_db #(
  parameter int STABLE = 10,
  parameter int CNT_W  = 4
) (
  input  logic clk_n,
  input  logic clr_n,
  input  logic btn,
  output logic level
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchroniser stage: btn is fully asynchronous to clk_n
  always_ff @(negedge clk_n or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce stage: any sample agreeing with the current level restarts the count
  always_ff @(negedge clk_n or negedge clr_n) begin
    if (!clr_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 != level) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

module sr_cmd_gen #(
  parameter int STABLE = 10,
  parameter int CNT_W  = 4
) (
  input  logic clk_n,
  input  logic clr_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic conflict,
  output logic db_set,
  output logic db_rst
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SET  = 2'd1;
  localparam logic [1:0] RST  = 2'd2;
  localparam logic [1:0] LOCK = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       s_nx;
  logic       r_nx;

  sr_cmd_db #(.STABLE(STABLE), .CNT_W(CNT_W)) u_db_set (
    .clk_n (clk_n),
    .clr_n (clr_n),
    .btn   (btn_set),
    .level (db_set)
  );

  sr_cmd_db #(.STABLE(STABLE), .CNT_W(CNT_W)) u_db_rst (
    .clk_n (clk_n),
    .clr_n (clr_n),
    .btn   (btn_rst),
    .level (db_rst)
  );

  // Arbitration: a held button losing exclusivity goes to LOCK ahead of release
  always_comb begin
    state_nx = state;
    s_nx     = 1'b0;
    r_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (db_set && db_rst) begin
          state_nx = LOCK;
        end else if (db_set) begin
          state_nx = SET;
          s_nx     = 1'b1;
        end else if (db_rst) begin
          state_nx = RST;
          r_nx     = 1'b1;
        end
      end
      SET: begin
        if (db_rst)       state_nx = LOCK;
        else if (!db_set) state_nx = IDLE;
      end
      RST: begin
        if (db_set)       state_nx = LOCK;
        else if (!db_rst) state_nx = IDLE;
      end
      default: begin
        if (!db_set && !db_rst) state_nx = IDLE;
      end
    endcase
  end

  // Output stage: strobes and conflict are registered so sr_ff sees full periods
  always_ff @(negedge clk_n or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nx;
      s        <= s_nx;
      r        <= r_nx;
      conflict <= (state_nx == LOCK);
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: history-based behavioural model compared every cycle,
// plus directed scenarios with hand-computed edge numbers.

module tb_sr_cmd_gen;

  localparam int STABLE = 10;
  localparam int FREE = 0, HOLD_S = 1, HOLD_R = 2, LOCKED = 3;

  logic clk_n = 1'b1;
  logic clr_n = 1'b0;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic s, r, conflict, db_set, db_rst;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  sr_cmd_gen #(.STABLE(STABLE), .CNT_W(4)) dut (
    .clk_n    (clk_n),
    .clr_n    (clr_n),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .s        (s),
    .r        (r),
    .conflict (conflict),
    .db_set   (db_set),
    .db_rst   (db_rst)
  );

  always #5 clk_n = ~clk_n;

  always @(negedge clk_n) ecount <= ecount + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Model: a debounced level flips once the synchronised sample (the button two
  // edges back) has disagreed with it on STABLE consecutive edges since its last flip.
  bit h [2][$];
  int since [2];
  bit mdb [2];
  int mode;
  bit ms, mr, mc;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      h[c].delete();
      since[c] = 0;
      mdb[c] = 1'b0;
    end
    mode = FREE;
    ms = 1'b0;
    mr = 1'b0;
    mc = 1'b0;
  endtask

  task automatic model_chan(input int c, input bit b);
    int dis;
    bit v;
    h[c].push_back(b);
    since[c]++;
    dis = 0;
    for (int k = 0; k < since[c]; k++) begin
      int idx;
      idx = h[c].size() - 3 - k;
      v = (idx >= 0) ? h[c][idx] : 1'b0;
      if (v != mdb[c]) dis++;
      else break;
    end
    if (dis >= STABLE) begin
      mdb[c] = ~mdb[c];
      since[c] = 0;
    end
  endtask

  task automatic model_step(input bit bs, input bit br);
    bit ds, dr;
    ds = mdb[0];
    dr = mdb[1];
    ms = 1'b0;
    mr = 1'b0;
    if (mode == LOCKED) begin
      if (!ds && !dr) mode = FREE;
    end else if (mode == FREE) begin
      if (ds && dr) mode = LOCKED;
      else if (ds) begin mode = HOLD_S; ms = 1'b1; end
      else if (dr) begin mode = HOLD_R; mr = 1'b1; end
    end else if (mode == HOLD_S) begin
      if (dr) mode = LOCKED;
      else if (!ds) mode = FREE;
    end else begin
      if (ds) mode = LOCKED;
      else if (!dr) mode = FREE;
    end
    mc = (mode == LOCKED);
    model_chan(0, bs);
    model_chan(1, br);
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk_n or negedge clr_n);
      if (!clr_n) model_reset();
      else model_step(btn_set, btn_rst);
    end
  end

  // Event tracking for the directed scenarios (edge numbers of observed outputs)
  int s_cnt, r_cnt, c_cnt, s_first, r_first, c_first, c_last, db_first;

  task automatic clear_track();
    s_cnt = 0; r_cnt = 0; c_cnt = 0;
    s_first = -1; r_first = -1; c_first = -1; c_last = -1; db_first = -1;
  endtask

  initial begin
    clear_track();
    forever begin
      @(posedge clk_n);
      chk("s", s, ms);
      chk("r", r, mr);
      chk("conflict", conflict, mc);
      chk("db_set", db_set, mdb[0]);
      chk("db_rst", db_rst, mdb[1]);
      chk("s_r_exclusive", int'(s & r), 0);
      if (s) begin s_cnt++; if (s_first < 0) s_first = ecount; end
      if (r) begin r_cnt++; if (r_first < 0) r_first = ecount; end
      if (conflict) begin c_cnt++; if (c_first < 0) c_first = ecount; c_last = ecount; end
      if (db_set && db_first < 0) db_first = ecount;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int e0;

  initial begin
    #1;
    chk("reset_s", s, 0);
    chk("reset_r", r, 0);
    chk("reset_conflict", conflict, 0);
    chk("reset_db_set", db_set, 0);
    chk("reset_db_rst", db_rst, 0);
    tick(3);
    clr_n = 1'b1;
    tick(3);

    // Clean set press
    clear_track();
    btn_set = 1'b1;
    e0 = ecount + 1;
    tick(30);
    chk("clean_db_rise_edge", db_first, e0 + 11);
    chk("clean_s_edge", s_first, e0 + 12);
    chk("clean_s_count", s_cnt, 1);
    chk("clean_r_count", r_cnt, 0);
    chk("clean_conflict_count", c_cnt, 0);

    // Asynchronous reset between edges while set is held
    chk("pre_async_db_set", db_set, 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_s", s, 0);
    chk("async_r", r, 0);
    chk("async_conflict", conflict, 0);
    chk("async_db_set", db_set, 0);
    chk("async_db_rst", db_rst, 0);
    tick(2);
    btn_set = 1'b0;
    tick(1);
    clr_n = 1'b1;
    tick(5);

    // Bounce: 4 edges high, 2 low, then high and held
    clear_track();
    btn_set = 1'b1;
    tick(4);
    btn_set = 1'b0;
    tick(2);
    btn_set = 1'b1;
    e0 = ecount + 1;
    tick(40);
    chk("bounce_s_count", s_cnt, 1);
    chk("bounce_s_edge", s_first, e0 + 12);
    btn_set = 1'b0;
    tick(20);

    // Overlap: set accepted, then reset pressed and released, then set released
    clear_track();
    btn_set = 1'b1;
    tick(20);
    chk("overlap_s_count", s_cnt, 1);
    btn_rst = 1'b1;
    e0 = ecount + 1;
    tick(20);
    chk("overlap_conflict_rise", c_first, e0 + 12);
    btn_rst = 1'b0;
    tick(20);
    chk("overlap_still_locked", conflict, 1);
    btn_set = 1'b0;
    e0 = ecount + 1;
    tick(20);
    chk("overlap_conflict_last", c_last, e0 + 11);
    chk("overlap_r_count", r_cnt, 0);
    chk("overlap_s_total", s_cnt, 1);

    // Simultaneous press
    clear_track();
    btn_set = 1'b1;
    btn_rst = 1'b1;
    e0 = ecount + 1;
    tick(20);
    chk("simul_conflict_edge", c_first, e0 + 12);
    chk("simul_s_count", s_cnt, 0);
    chk("simul_r_count", r_cnt, 0);
    btn_set = 1'b0;
    btn_rst = 1'b0;
    tick(20);
    chk("simul_conflict_cleared", conflict, 0);

    // Reset pulse with the reset-button counter at 5
    clear_track();
    btn_rst = 1'b1;
    tick(7);
    #2;
    clr_n = 1'b0;
    @(posedge clk_n);
    clr_n = 1'b1;
    clear_track();
    e0 = ecount + 1;
    tick(30);
    chk("middeb_r_edge", r_first, e0 + 12);
    chk("middeb_r_count", r_cnt, 1);
    chk("middeb_s_count", s_cnt, 0);
    btn_rst = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

- Front-end conditioner for the `sr_ff` stage.
- Synchronises and debounces two raw push-button inputs, set and reset.
- Converts each clean press into a single one-clock-period `s` or `r` strobe for the downstream SR flip-flop.
- Guarantees `s` and `r` are never high together; simultaneous or overlapping presses are locked out and flagged on `conflict`.
- Clocked on the falling edge of `clk_n`, the same edge as the flip-flop it drives.

## Interface

Parameters:
- `STABLE`, default 10: consecutive `clk_n` falling edges a synchronised input must differ from its debounced state before that state flips. Legal range is 1..2^CNT_W−1.
- `CNT_W`, default 4: width of each debounce counter.

Ports:
- `clk_n`, input, 1: clock; all state updates on the falling edge.
- `clr_n`, input, 1: reset, asynchronous, active-low.
- `btn_set`, input, 1: raw set button, active-high, asynchronous to `clk_n`, may bounce.
- `btn_rst`, input, 1: raw reset button, active-high, asynchronous, may bounce.
- `s`, output, 1: set strobe to the SR flip-flop; high for exactly one `clk_n` period per accepted press.
- `r`, output, 1: reset strobe; high for exactly one `clk_n` period per accepted press.
- `conflict`, output, 1: high while the block is in the LOCK state.
- `db_set`, output, 1: debounced set level, for observability.
- `db_rst`, output, 1: debounced reset level, for observability.

## Operation

Per channel (set and reset are identical):
- **Synchroniser:** two-flop synchroniser, `sync1` then `sync2`.
- **Debounce counter:** counts when `sync2` differs from `db_*` and clears when they match.
- **Debounce flip:** on the edge where the count would reach `STABLE`, `db_*` toggles and the counter clears.
- **No saturation needed:** the counter never exceeds `STABLE`.
- **Symmetric:** press and release are debounced identically.

FSM states: IDLE, SET, RST, LOCK. Transitions, sampled on `db_set` / `db_rst`:
- **IDLE:**
  - set=1, rst=0 → SET; assert `s` for one period.
  - rst=1, set=0 → RST; assert `r` for one period.
  - both=1 → LOCK.
  - otherwise stay in IDLE.
- **SET:**
  - set=0 → IDLE.
  - rst=1 → LOCK.
  - No further `s` while held.
- **RST:**
  - rst=0 → IDLE.
  - set=1 → LOCK.
  - No further `r` while held.
- **LOCK:**
  - Leave only when both are 0, to IDLE.
  - Releasing just one button never emits a strobe.
  - `conflict` = 1 while in LOCK.

Output rules:
- `s`, `r` and `conflict` are registered.
- `s` and `r` are mutually exclusive by construction.
- A strobe is issued only on entry from IDLE.

Reset (`clr_n` = 0, asynchronous):
- Synchronisers, counters, `db_set`, `db_rst`, `s`, `r` and `conflict` all go to 0.
- FSM goes to IDLE.
- All outputs read 0 without waiting for a clock edge.
- On reset mid-debounce, the partial count is discarded.
- A button still held after `clr_n` rises is debounced from scratch and produces a fresh strobe.

## Timing

- **Edge numbering:** E0 is the first `clk_n` falling edge that samples `btn_*` = 1 into `sync1`, with the button held stable from then on.
- **Synchroniser:** `sync2` = 1 after E1.
- **Debounce:** the counter advances on E2 … E(STABLE+1); `db_*` rises at E(STABLE+1). With the default, that is E11.
- **Strobe:** the FSM sees `db_*` and raises `s`/`r` at E(STABLE+2), deasserting it at E(STABLE+3). With the default, high from E12 to E13.
- **Latency:** STABLE+2 falling edges from first sample to strobe.
- **Release:** takes STABLE+1 edges to clear `db_*`; the FSM leaves SET/RST one edge later.
- **Bounce:** any sample matching the current debounced level clears the counter, so E0 effectively restarts at the last bounce.
- **Downstream hand-off:** the strobe is stable for a full period, so `sr_ff` captures it on the next falling edge after assertion.
- **`conflict` timing:** rises on the edge the FSM enters LOCK and falls on the edge it enters IDLE.

## Test plan

1. **Asynchronous reset:**
   - Stimulus: after `s` has been strobed and `db_set` = 1, pull `clr_n` low between clock edges.
   - Required: `s`, `r`, `conflict`, `db_set` and `db_rst` all 0 before the next edge; the FSM returns to IDLE.
2. **Clean set press (STABLE = 10):**
   - Stimulus: hold `btn_set` = 1 for 30 edges.
   - Required: `db_set` rises at E11; `s` is high from E12 to E13 only; `r` = 0; `conflict` = 0 throughout.
3. **Bounce:**
   - Stimulus: `btn_set` at 1 for 4 edges, 0 for 2 edges, 1 for 3 edges, then 1 held.
   - Required: exactly one `s` pulse, 12 edges after the final rising sample; no pulse from the early fragments.
4. **Overlap lockout:**
   - Stimulus: hold set until `s` fires, then press `btn_rst`; release `btn_rst`, then release `btn_set`.
   - Required: no `r` at any point; `conflict` = 1 from the edge after `db_rst` rises until the edge after both debounced levels are 0; no strobe on either release.
5. **Simultaneous press:**
   - Stimulus: `btn_set` and `btn_rst` both rise before the same edge and are held.
   - Required: `conflict` = 1 at E12; `s` = `r` = 0 throughout.
6. **Reset mid-debounce:**
   - Stimulus: `btn_rst` held; pulse `clr_n` low when the counter is at 5; keep `btn_rst` held afterwards.
   - Required: the counter is cleared; `r` is high exactly one period, 12 edges after the first post-reset sampling edge.
